// File: rtl/toggle_hs_receiver.sv
// -----------------------------------------------------------------------------
// toggle_hs_receiver
//   Receiving end of a 2-phase toggle handshake. The sender flips req_tgl once
//   per word and holds req_data until ack_tgl matches its request level. The
//   request level is synchronised into clk. Each level change is accepted into
//   a small first-word-fall-through FIFO, and ack_tgl then echoes the accepted
//   level. The FIFO head is presented on a valid/ready interface.
//
// Ports
//   clk       in   rising-edge clock
//   clr       in   asynchronous, active-high reset (shared with the sender)
//   req_tgl   in   request toggle from sender, asynchronous to clk
//   req_data  in   request payload, stable while a request is outstanding
//   ack_tgl   out  acknowledge toggle back to the sender (registered)
//   out_valid out  FIFO head valid
//   out_data  out  FIFO head data (don't-care while out_valid=0)
//   out_ready in   consumer pops the head when out_valid && out_ready
//   count     out  FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module toggle_hs_receiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     req_tgl,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     ack_tgl,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_seen_q, req_seen_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic req_sync;
  logic pending;
  logic accept;
  logic pop;

  // Synchroniser stage: req_tgl shifts in at bit 0, req_sync is the last flop.
  assign req_sync = sync_q[SYNC_STAGES-1];

  // Accept stage: the full check uses the registered count, so a pop on the
  // same edge never makes room for an incoming word (no full-bypass).
  assign pending = (req_sync != req_seen_q);
  assign accept  = pending && (count_q != DEPTH_C);
  assign pop     = (count_q != '0) && out_ready;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], req_tgl};
    req_seen_d = req_seen_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept) begin
      req_seen_d = req_sync;
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Simultaneous accept and pop leave the occupancy unchanged.
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q     <= '0;
      req_seen_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      req_seen_q <= req_seen_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage stage: payload only, so no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= req_data;
    end
  end

  // Output stage: ack echoes the last accepted level straight from a flop.
  assign ack_tgl   = req_seen_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule
